burst_ram_arbiter: RTL and testbench
====================================

# burst_ram_arbiter

Two-client arbiter that shares one BurstRAM port (SDRAM controller or its simulation model) between two cache controllers, e.g. instruction cache (client 0) and data cache (client 1). Grants whole bursts atomically and forwards the winner's command, address and write beats. Steers read-data-valid back to the owning client only. Sits between the Cache instances and BurstRAM; each Cache sees an unmodified `br_*` style interface plus a one-cycle acknowledge.

## Interface
- DEPTH_BITWIDTH, 4, BurstRAM address width (8-byte words)
- BURST_COUNT, 4, 64-bit beats per burst, read or write

Ports:
- clk  in  1  system clock; all state on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- c0_cmd, c1_cmd  in  1  0: read, 1: write
- c0_cmd_en, c1_cmd_en  in  1  request; held with cmd/addr/first wr_data stable until ack
- c0_addr, c1_addr  in  DEPTH_BITWIDTH  burst start address
- c0_wr_data, c1_wr_data  in  64  write beat
- c0_data_mask, c1_data_mask  in  8  forwarded unchanged
- c0_ack, c1_ack  out  1  request accepted this cycle
- c0_rd_data_valid, c1_rd_data_valid  out  1  read beat valid for this client
- rd_data  out  64  br_rd_data broadcast to both clients
- br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask  out  1/1/DEPTH_BITWIDTH/64/8  to BurstRAM
- br_rd_data  in  64; br_rd_data_valid, br_init_calib, br_busy  in  1

## Operation
- States: IDLE, WRITE (remaining beats), READ (awaiting beats).
- IDLE: eligible only when br_init_calib=1 and br_busy=0. With one request pending, it wins; with both, round-robin: the client not granted last wins. Winner's cmd/addr/wr_data/data_mask drive br_* combinationally, br_cmd_en=1, winner's ack=1, same cycle. Record owner; flip last-grant.
- Write grant: go to WRITE, beat counter = BURST_COUNT-1. Owner supplies beats 2..BURST_COUNT on consecutive cycles after ack; br_wr_data/br_data_mask follow owner each cycle; counter decrements; at 0 return to IDLE (BURST_COUNT=1 returns to IDLE immediately).
- Read grant: go to READ, counter = BURST_COUNT. Each br_rd_data_valid asserts owner's cN_rd_data_valid only and decrements; after last beat return to IDLE. Non-owner valid stays 0.
- Outside bursts br_cmd_en=0 and br_* data follow client 0 (don't care).
- A request arriving mid-burst waits; no ack until IDLE and arbitration conditions met.
- Counter width ceil(log2(BURST_COUNT+1)); no wrap: decrement only while nonzero.

## Timing
- Reset (sys_rst_n=0, any time incl. mid-burst): state IDLE, counter 0, owner 0, last-grant = client 1 (so client 0 wins first tie); br_cmd_en, c0_ack, c1_ack, c0_rd_data_valid, c1_rd_data_valid all 0 immediately (combinational outputs gated by reset). Abandoned bursts are not completed; BurstRAM is reset by the same signal.
- Grant latency: 0 cycles from request in eligible IDLE to ack/br_cmd_en.
- Back-to-back: after the last write beat or last read valid, IDLE in next cycle; next grant possible that cycle if br_busy=0.
- Ack is a single-cycle pulse per burst; client must drop or change cmd_en after ack.
- rd_data_valid steering adds 0 latency (combinational from br_rd_data_valid and owner).

## Configuration
- BURST_RAM_ARBITER_FIXED_PRIORITY_EN defined: client 0 always wins ties; last-grant register unused. Undefined (default): round-robin as above.

## Test plan
- Reset with both requesting: all outputs 0; after release (br_init_calib=1, br_busy=0) client 0 acked first, br_addr = c0_addr.
- Client 0 write addr 2, beats 0x11..11,0x22..22,0x33..33,0x44..44; client 1 read addr 2 pending -> c1 acked only after 4th beat; c1 receives 4 valids with data 0x11..11..0x44..44; c0_rd_data_valid stays 0.
- Both request reads repeatedly -> grants alternate 0,1,0,1; with BURST_RAM_ARBITER_FIXED_PRIORITY_EN -> 0,0,0 while client 0 keeps requesting.
- Request while br_busy=1 or br_init_calib=0 -> no ack, br_cmd_en=0 until condition clears, then ack same cycle.
- sys_rst_n pulsed low in 2nd beat of a read -> valids and br_cmd_en drop to 0 immediately; after reset new request granted from IDLE.
- Single client 1 read addr 15 (top of DEPTH_BITWIDTH=4) -> br_addr=15, exactly BURST_COUNT c1_rd_data_valid pulses, then IDLE.

Source files
------------

// File: rtl/burst_ram_arbiter_if.sv
// burst_ram_arbiter_if: bundles both cache-side br_* style client ports, the
// shared BurstRAM port and a state debug tap.
// Handshake: a client holds cN_cmd_en with cmd/addr/first beat stable until
// cN_ack pulses for one cycle. A write then streams the remaining beats on the
// following consecutive cycles. Read beats are qualified by cN_rd_data_valid.
// Modports: slave = arbiter view, master = clients + BurstRAM (environment).
interface burst_ram_arbiter_if #(
    parameter int DEPTH_BITWIDTH = 4
);
    logic                      c0_cmd,            c1_cmd;
    logic                      c0_cmd_en,         c1_cmd_en;
    logic [DEPTH_BITWIDTH-1:0] c0_addr,           c1_addr;
    logic [63:0]               c0_wr_data,        c1_wr_data;
    logic [7:0]                c0_data_mask,      c1_data_mask;
    logic                      c0_ack,            c1_ack;
    logic                      c0_rd_data_valid,  c1_rd_data_valid;
    logic [63:0]               rd_data;
    logic                      br_cmd;
    logic                      br_cmd_en;
    logic [DEPTH_BITWIDTH-1:0] br_addr;
    logic [63:0]               br_wr_data;
    logic [7:0]                br_data_mask;
    logic [63:0]               br_rd_data;
    logic                      br_rd_data_valid;
    logic                      br_init_calib;
    logic                      br_busy;
    logic [1:0]                dbg_state;

    modport slave (
        input  c0_cmd, c1_cmd, c0_cmd_en, c1_cmd_en, c0_addr, c1_addr,
               c0_wr_data, c1_wr_data, c0_data_mask, c1_data_mask,
               br_rd_data, br_rd_data_valid, br_init_calib, br_busy,
        output c0_ack, c1_ack, c0_rd_data_valid, c1_rd_data_valid, rd_data,
               br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask, dbg_state
    );

    modport master (
        output c0_cmd, c1_cmd, c0_cmd_en, c1_cmd_en, c0_addr, c1_addr,
               c0_wr_data, c1_wr_data, c0_data_mask, c1_data_mask,
               br_rd_data, br_rd_data_valid, br_init_calib, br_busy,
        input  c0_ack, c1_ack, c0_rd_data_valid, c1_rd_data_valid, rd_data,
               br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask, dbg_state
    );
endinterface

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: shares one BurstRAM port between two cache clients.
// Whole bursts are granted atomically; ties are round-robin by default.
// Optional macro BURST_RAM_ARBITER_FIXED_PRIORITY_EN: client 0 wins every tie.
// DEPTH_BITWIDTH must match the interface instance parameter.
// dbg_state encoding: 0 IDLE, 1 WRITE, 2 READ.
module burst_ram_arbiter #(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int BURST_COUNT    = 4
) (
    input  logic                   clk,
    input  logic                   sys_rst_n,
    burst_ram_arbiter_if.slave     bus
);
    localparam int CNT_W = $clog2(BURST_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_RD = CNT_W'(BURST_COUNT);
    localparam logic [CNT_W-1:0] CNT_WR = CNT_W'(BURST_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             r_owner, w_owner_nxt;
`ifndef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
    logic             r_last_grant, w_last_grant_nxt;
`endif

    logic w_eligible;
    logic w_grant;
    logic w_winner;
    logic w_sel;
    logic w_win_cmd;
    logic w_rd_beat;

    // Arbitration: pick the winner and the client whose data drives br_*.
    always_comb begin
        w_eligible = (r_state == ST_IDLE) && bus.br_init_calib && !bus.br_busy;
        w_grant    = w_eligible && (bus.c0_cmd_en || bus.c1_cmd_en);
        if (bus.c0_cmd_en && bus.c1_cmd_en) begin
`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
            w_winner = 1'b0;
`else
            w_winner = ~r_last_grant;
`endif
        end else begin
            w_winner = !bus.c0_cmd_en;
        end
        // During a burst the owner steers the data path; otherwise client 0.
        if (w_grant) begin
            w_sel = w_winner;
        end else if (r_state != ST_IDLE) begin
            w_sel = r_owner;
        end else begin
            w_sel = 1'b0;
        end
        w_win_cmd = w_winner ? bus.c1_cmd : bus.c0_cmd;
        w_rd_beat = (r_state == ST_READ) && bus.br_rd_data_valid && (r_cnt != '0);
    end

    // Output path: forward selected client, gate strobes with reset.
    always_comb begin
        bus.br_cmd           = w_sel ? bus.c1_cmd       : bus.c0_cmd;
        bus.br_addr          = w_sel ? bus.c1_addr      : bus.c0_addr;
        bus.br_wr_data       = w_sel ? bus.c1_wr_data   : bus.c0_wr_data;
        bus.br_data_mask     = w_sel ? bus.c1_data_mask : bus.c0_data_mask;
        bus.br_cmd_en        = sys_rst_n && w_grant;
        bus.c0_ack           = sys_rst_n && w_grant && !w_winner;
        bus.c1_ack           = sys_rst_n && w_grant &&  w_winner;
        bus.c0_rd_data_valid = sys_rst_n && w_rd_beat && !r_owner;
        bus.c1_rd_data_valid = sys_rst_n && w_rd_beat &&  r_owner;
        bus.rd_data          = bus.br_rd_data;
        bus.dbg_state        = r_state;
    end

    // Next state: burst sequencing and beat counting.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
`ifndef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
        w_last_grant_nxt = r_last_grant;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_owner_nxt = w_winner;
`ifndef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
                    w_last_grant_nxt = w_winner;
`endif
                    if (w_win_cmd) begin
                        // Beat 1 went out with the command itself.
                        w_cnt_nxt   = CNT_WR;
                        w_state_nxt = (BURST_COUNT == 1) ? ST_IDLE : ST_WRITE;
                    end else begin
                        w_cnt_nxt   = CNT_RD;
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                if (w_rd_beat) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_owner <= 1'b0;
`ifndef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
`ifndef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
            r_last_grant <= w_last_grant_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb_burst_ram_arbiter: directed bench with a burst-level reference model,
// a simple BurstRAM behavioural model and hand-computed literal expectations.
module tb_burst_ram_arbiter;
    localparam int DW = 4;
    localparam int BC = 4;

    logic clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 clk = ~clk;

    burst_ram_arbiter_if #(.DEPTH_BITWIDTH(DW)) bus();

    burst_ram_arbiter #(.DEPTH_BITWIDTH(DW), .BURST_COUNT(BC)) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (burst level) ----------------
    int          m_left  = 0;   // beats still owed by the burst in progress
    int          m_owner = 0;
    int          m_last  = 1;
    bit          m_write = 1'b0;
    int          m_addr  = 0;
    int          m_idx   = 0;
    logic [63:0] mem_exp [64];
    logic [63:0] ram     [64];
    int          grant_log[$];
    int          ack_cyc[2];
    int          rdv_cnt[2];
    logic [63:0] rd1_q[$];
    int          last_br_addr = 0;

    always @(negedge clk) begin
        logic r0, r1, g, rv, w_cmd;
        int   w;
        logic [DW-1:0] w_addr;
        logic [63:0]   w_data, o_data;
        logic [7:0]    w_mask, o_mask;
        if (!sys_rst_n) begin
            m_left = 0; m_owner = 0; m_last = 1;
            check("rst_br_cmd_en", bus.br_cmd_en, 0);
            check("rst_c0_ack", bus.c0_ack, 0);
            check("rst_c1_ack", bus.c1_ack, 0);
            check("rst_c0_rdv", bus.c0_rd_data_valid, 0);
            check("rst_c1_rdv", bus.c1_rd_data_valid, 0);
        end else begin
            r0 = bus.c0_cmd_en;
            r1 = bus.c1_cmd_en;
            g  = bus.br_init_calib && !bus.br_busy && (m_left == 0) && (r0 || r1);
`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
            if (r0 && r1) w = 0; else w = r0 ? 0 : 1;
`else
            if (r0 && r1) w = (m_last == 0) ? 1 : 0; else w = r0 ? 0 : 1;
`endif
            w_cmd  = w ? bus.c1_cmd       : bus.c0_cmd;
            w_addr = w ? bus.c1_addr      : bus.c0_addr;
            w_data = w ? bus.c1_wr_data   : bus.c0_wr_data;
            w_mask = w ? bus.c1_data_mask : bus.c0_data_mask;
            o_data = m_owner ? bus.c1_wr_data   : bus.c0_wr_data;
            o_mask = m_owner ? bus.c1_data_mask : bus.c0_data_mask;
            rv = !m_write && (m_left > 0) && bus.br_rd_data_valid;
            check("br_cmd_en", bus.br_cmd_en, g);
            check("c0_ack", bus.c0_ack, g && (w == 0));
            check("c1_ack", bus.c1_ack, g && (w == 1));
            check("c0_rdv", bus.c0_rd_data_valid, rv && (m_owner == 0));
            check("c1_rdv", bus.c1_rd_data_valid, rv && (m_owner == 1));
            if (bus.c0_rd_data_valid) rdv_cnt[0]++;
            if (bus.c1_rd_data_valid) begin rdv_cnt[1]++; rd1_q.push_back(bus.rd_data); end
            if (g) begin
                check("grant_br_addr", bus.br_addr, w_addr);
                check("grant_br_cmd", bus.br_cmd, w_cmd);
                check("grant_br_wr_data", bus.br_wr_data, w_data);
                check("grant_br_mask", bus.br_data_mask, w_mask);
                grant_log.push_back(w);
                ack_cyc[w]   = cyc;
                last_br_addr = int'(bus.br_addr);
                m_owner = w; m_last = w; m_write = w_cmd; m_addr = int'(w_addr);
                if (w_cmd) begin
                    mem_exp[m_addr] = w_data; m_idx = 1; m_left = BC - 1;
                end else begin
                    m_idx = 0; m_left = BC;
                end
            end else if (m_left > 0 && m_write) begin
                check("beat_br_wr_data", bus.br_wr_data, o_data);
                check("beat_br_mask", bus.br_data_mask, o_mask);
                mem_exp[m_addr + m_idx] = o_data;
                m_idx++; m_left--;
            end else if (rv) begin
                check("rd_data", bus.rd_data, mem_exp[m_addr + m_idx]);
                m_idx++; m_left--;
            end else if (m_left == 0) begin
                check("idle_br_wr_data", bus.br_wr_data, bus.c0_wr_data);
            end
        end
    end

    // ---------------- BurstRAM behavioural model ----------------
    int wr_left = 0, wr_idx = 0, wr_addr = 0;
    int rd_left = 0, rd_idx = 0, rd_addr = 0, rd_delay = 0;
    always @(posedge clk) begin
        if (!sys_rst_n) begin
            wr_left <= 0; rd_left <= 0; rd_delay <= 0;
            bus.br_rd_data_valid <= 1'b0;
            bus.br_rd_data       <= '0;
        end else begin
            if (bus.br_cmd_en && bus.br_cmd) begin
                ram[int'(bus.br_addr)] <= bus.br_wr_data;
                wr_addr <= int'(bus.br_addr); wr_idx <= 1; wr_left <= BC - 1;
            end else if (wr_left > 0) begin
                ram[wr_addr + wr_idx] <= bus.br_wr_data;
                wr_idx <= wr_idx + 1; wr_left <= wr_left - 1;
            end
            if (bus.br_cmd_en && !bus.br_cmd) begin
                rd_addr <= int'(bus.br_addr); rd_idx <= 0; rd_left <= BC; rd_delay <= 2;
                bus.br_rd_data_valid <= 1'b0;
            end else if (rd_left > 0 && rd_delay > 0) begin
                rd_delay <= rd_delay - 1;
                bus.br_rd_data_valid <= 1'b0;
            end else if (rd_left > 0) begin
                bus.br_rd_data_valid <= 1'b1;
                bus.br_rd_data <= ram[rd_addr + rd_idx];
                rd_idx <= rd_idx + 1; rd_left <= rd_left - 1;
            end else begin
                bus.br_rd_data_valid <= 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_client(input int c, input logic cmd, input logic en,
                              input logic [DW-1:0] addr, input logic [63:0] d,
                              input logic [7:0] m);
        if (c == 0) begin
            bus.c0_cmd = cmd; bus.c0_cmd_en = en; bus.c0_addr = addr;
            bus.c0_wr_data = d; bus.c0_data_mask = m;
        end else begin
            bus.c1_cmd = cmd; bus.c1_cmd_en = en; bus.c1_addr = addr;
            bus.c1_wr_data = d; bus.c1_data_mask = m;
        end
    endtask

    // Issue one burst; write beat k carries d0*(k+1).
    task automatic do_req(input int c, input logic cmd, input logic [DW-1:0] addr,
                          input logic [63:0] d0);
        int  t   = 0;
        bit  got = 1'b0;
        set_client(c, cmd, 1'b1, addr, d0, 8'hA0);
        while (!got && t < 200) begin
            @(negedge clk);
            if ((c == 0 && bus.c0_ack) || (c == 1 && bus.c1_ack)) got = 1'b1;
            else t++;
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL ack_timeout: client %0d got no ack required within 200 cycles", c);
            set_client(c, cmd, 1'b0, addr, d0, 8'hA0);
            return;
        end
        @(posedge clk); #1;
        set_client(c, cmd, 1'b0, addr, d0, 8'hA0);
        if (cmd) begin
            for (int k = 1; k < BC; k++) begin
                set_client(c, cmd, 1'b0, addr, d0 * 64'(k + 1), 8'(8'hA0 + k));
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (m_left != 0 && t < 300) begin
            @(negedge clk); #1;
            t++;
        end
        n_cmp++;
        if (m_left != 0) begin
            n_err++;
            $display("FAIL idle_timeout: %0d beats outstanding, required 0", m_left);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int base0, base1, rel_cyc;
        int exp_alt[6];
        for (int i = 0; i < 64; i++) begin
            ram[i]     = 64'hA5A5_0000_0000_0000 | 64'(i);
            mem_exp[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        end
        rdv_cnt[0] = 0; rdv_cnt[1] = 0; ack_cyc[0] = 0; ack_cyc[1] = 0;
        bus.br_init_calib = 1'b1;
        bus.br_busy       = 1'b0;
        set_client(0, 1'b0, 1'b0, '0, '0, '0);
        set_client(1, 1'b0, 1'b0, '0, '0, '0);

        // Reset with both requesting, then client 0 wins the first tie.
        fork
            do_req(0, 1'b0, 4'd3, 64'h0);
            do_req(1, 1'b0, 4'd7, 64'h0);
            begin
                repeat (3) @(posedge clk);
                #2;
                check("t1_rst_c0_ack", bus.c0_ack, 0);
                check("t1_rst_cmd_en", bus.br_cmd_en, 0);
                sys_rst_n = 1'b1;
                #1;
                check("t1_first_c0_ack", bus.c0_ack, 1);
                check("t1_first_c1_ack", bus.c1_ack, 0);
                check("t1_first_addr", bus.br_addr, 3);
            end
        join
        wait_idle();
        check("t1_order0", grant_log[0], 0);
        check("t1_order1", grant_log[1], 1);

        // Client 0 write, client 1 read of the same address waits for it.
        rd1_q.delete();
        base0 = rdv_cnt[0];
        fork
            do_req(0, 1'b1, 4'd2, 64'h1111_1111_1111_1111);
            begin @(posedge clk); #1; do_req(1, 1'b0, 4'd2, 64'h0); end
        join
        wait_idle();
        check("t2_ack_gap", ack_cyc[1] - ack_cyc[0], 4);
        check("t2_nbeats", rd1_q.size(), 4);
        if (rd1_q.size() == 4) begin
            check("t2_beat0", rd1_q[0], 64'h1111_1111_1111_1111);
            check("t2_beat1", rd1_q[1], 64'h2222_2222_2222_2222);
            check("t2_beat2", rd1_q[2], 64'h3333_3333_3333_3333);
            check("t2_beat3", rd1_q[3], 64'h4444_4444_4444_4444);
        end
        check("t2_c0_no_valid", rdv_cnt[0] - base0, 0);

        // Both clients hammer reads: fairness policy decides the order.
        grant_log.delete();
        fork
            begin for (int i = 0; i < 3; i++) do_req(0, 1'b0, 4'(4 + i), 64'h0); end
            begin for (int i = 0; i < 3; i++) do_req(1, 1'b0, 4'(8 + i), 64'h0); end
        join
        wait_idle();
`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
        exp_alt = '{0, 0, 0, 1, 1, 1};
`else
        exp_alt = '{0, 1, 0, 1, 0, 1};
`endif
        check("t3_ngrants", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check($sformatf("t3_grant%0d", i), grant_log[i], exp_alt[i]);

        // Busy, then not calibrated: no grant until the condition clears.
        bus.br_busy = 1'b1;
        rel_cyc = 0;
        fork
            do_req(0, 1'b0, 4'd5, 64'h0);
            begin repeat (3) @(posedge clk); #1; bus.br_busy = 1'b0; rel_cyc = cyc; end
        join
        check("t4_busy_ack_cycle", ack_cyc[0], rel_cyc);
        wait_idle();
        bus.br_init_calib = 1'b0;
        fork
            do_req(1, 1'b0, 4'd6, 64'h0);
            begin repeat (4) @(posedge clk); #1; bus.br_init_calib = 1'b1; rel_cyc = cyc; end
        join
        check("t4_calib_ack_cycle", ack_cyc[1], rel_cyc);
        wait_idle();

        // Reset during the second beat of a read.
        base0 = rdv_cnt[0];
        do_req(0, 1'b0, 4'd2, 64'h0);
        for (int t = 0; t < 50 && rdv_cnt[0] < base0 + 2; t++) begin
            @(negedge clk); #1;
        end
        check("t5_reached_beat2", rdv_cnt[0] - base0, 2);
        sys_rst_n = 1'b0;
        #1;
        check("t5_c0_rdv_drop", bus.c0_rd_data_valid, 0);
        check("t5_c1_rdv_drop", bus.c1_rd_data_valid, 0);
        check("t5_cmd_en_drop", bus.br_cmd_en, 0);
        repeat (2) @(posedge clk);
        #1;
        check("t5_no_beats_in_rst", rdv_cnt[0] - base0, 2);
        sys_rst_n = 1'b1;
        grant_log.delete();
        fork
            do_req(1, 1'b0, 4'd10, 64'h0);
            do_req(0, 1'b0, 4'd9, 64'h0);
        join
        wait_idle();
        check("t5_post_rst_first", grant_log[0], 0);

        // Top address, single client.
        base1 = rdv_cnt[1];
        do_req(1, 1'b0, 4'd15, 64'h0);
        check("t6_br_addr", last_br_addr, 15);
        wait_idle();
        @(posedge clk); #1;
        check("t6_nvalid", rdv_cnt[1] - base1, BC);
        check("t6_idle", bus.dbg_state, 0);
        repeat (4) @(posedge clk);
        check("t6_no_extra_valid", rdv_cnt[1] - base1, BC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
